dimm_err_inj_sched: RTL and testbench
=====================================

# dimm_err_inj_sched

Scheduler that arbitrates DIMM error-injection requests from up to four test requesters and sequences each granted request against the DRAM command bus. It watches ACTIVATE and WRITE commands on rank 0 and counts out the write latency. It then drives a per-beat injection strobe, mode, nibble position and bit mask to the DIMM-side injector for one burst. It sits in the manycore bench between test-level error controls and the DQ/CB forcing monitor.

## Interface
- `NREQ`, default 4: number of requesters (fixed at 4 in this release).
- `BURST_BEATS`, default 4: injection beats per granted WRITE.
- `ARM_TIMEOUT`, default 1500: cycles a grant may wait for ACT→WRITE before it is aborted.
- `clk` in 1: bench DRAM clock; all logic on posedge.
- `DRAM_RST_L` in 1: reset, asynchronous, active-high.
- `DRAM_CS_L` in 2: chip selects; only bit 0 is decoded.
- `DRAM_BA` in 3: bank address.
- `DRAM_RAS_L`, `DRAM_CAS_L`, `DRAM_WE_L` in 1 each: command bus.
- `cas_latency` in 3: CAS latency, sampled at grant.
- `bank_sel` in 3: bank filter, used only with the macro enabled.
- `req_valid` in NREQ: per-requester request, level.
- `req_mode` in 2*NREQ: per-requester mode: 0 = SECC data, 1 = MECC data, 2 = ECC invert, 3 = failover nibble.
- `req_ack` out NREQ: one-cycle pulse when that requester's burst completes.
- `req_abort` out NREQ: one-cycle pulse on timeout.
- `busy` out 1: high in any state except IDLE.
- `inj_en` out 1: injection strobe, one cycle per beat.
- `inj_mode` out 2: mode of the active grant.
- `inj_beat` out 2: beat index, 0..BURST_BEATS-1.
- `inj_nib` out 5: target nibble, 0..31.
- `inj_bits` out 4: XOR mask; never 0.

## Operation
- Reset: all outputs are 0, state is IDLE, round-robin pointer is 0, LFSR is 16'hACE1.
- IDLE: if any `req_valid` is set, grant round-robin starting at the pointer. Latch the grantee index, its mode, and the write delay WD. Go to ARMED. The pointer advances to grantee+1 mod NREQ.
- WD mapping: CL4→4, CL5→6, CL6→8, CL7→10; any other CL gives CL−1 (CL3→2).
- ARMED: on an ACT command (CS_L[0]=0, RAS_L=0, CAS_L=1, WE_L=1), go to ACTV.
- ACTV: on a WRITE command (CS_L[0]=0, RAS_L=1, CAS_L=0, WE_L=0), go to WAIT with the counter at 0. A second ACT in ACTV is ignored.
- WAIT: the counter increments each cycle. When counter==WD, go to INJ with beat 0.
- INJ: `inj_en`=1 each cycle, `inj_beat` = beat. After beat BURST_BEATS-1, go to DONE.
- DONE: pulse `req_ack[grantee]` and return to IDLE.
- Timeout: a counter runs in ARMED and ACTV. When it reaches ARM_TIMEOUT, pulse `req_abort[grantee]` for one cycle and go to IDLE. The counter is not active in WAIT or INJ.
- The grantee's `req_valid` dropping after grant is ignored; the burst completes.
- LFSR: 16-bit, polynomial x^16+x^14+x^13+x^11+1. It steps every cycle in which `inj_en` is high.
- Per beat: `inj_nib` = lfsr[4:0]. `inj_bits` = lfsr[8:5], with 4'h0 replaced by 4'h1.
- ECC-invert mode: `inj_nib` is forced to lfsr[1:0] so the target lies in CB range.
- Asserting reset mid-burst drops `inj_en` immediately, with no ack or abort.

## Timing
- Grant latency: 1 cycle from `req_valid` in IDLE to ARMED.
- First `inj_en`: WD+1 cycles after the cycle in which WRITE is sampled.
- Burst: exactly BURST_BEATS consecutive `inj_en` cycles.
- Ack: 1 cycle after the last beat.
- Back-to-back: the next grant is possible in the cycle after DONE.
- Minimum request-to-request period: 1 + (ACT latency) + (WRITE latency) + WD + 1 + BURST_BEATS + 1 cycles.
- Simultaneous ACT and timeout expiry in ARMED: timeout wins.
- Command with X/Z on any command bit: treated as no command.

## Configuration
- `DIMM_ERR_INJ_BANK_FILTER_EN`
- Defined: ACT and WRITE are qualified additionally by `DRAM_BA === bank_sel`.
- Undefined: all banks qualify and `bank_sel` is unused.

## Structure
- Shared package `dimm_err_inj_pkg`:
  - state enum (IDLE, ARMED, ACTV, WAIT, INJ, DONE);
  - mode encodings;
  - the CL→WD mapping function;
  - LFSR seed and taps.
- Sub-module `dimm_err_rr_arb`: 4-way round-robin arbiter with pointer register and one-hot grant.

## Test plan
- CL=3, req_valid=4'b0001 mode 0, ACT then WRITE 5 cycles later → first `inj_en` 3 cycles after WRITE, 4 beats with `inj_beat` 0..3, then `req_ack`=4'b0001.
- CL=6 → `inj_en` first asserts 9 cycles after WRITE.
- req_valid=4'b1111 held → grants in order 0,1,2,3,0; each `req_ack` bit pulses once per round.
- Grant with no ACT for 1500 cycles → `req_abort[grantee]` pulses at cycle 1500 and `busy` falls the next cycle.
- Reset asserted during beat 2 → `inj_en`=0 the same cycle, no ack, LFSR is 16'hACE1.
- Macro defined, bank_sel=3, WRITE to BA=1 → no injection; WRITE to BA=3 → injection proceeds. Mode 2 grant → `inj_nib` stays ≤3 and `inj_bits` is never 0.

Source files
------------

// File: rtl/dimm_err_inj_pkg.sv
// rtl/dimm_err_inj_pkg.sv - shared types, encodings and helpers for the DIMM error-injection scheduler
package dimm_err_inj_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ACTV  = 3'd2,
        WAIT  = 3'd3,
        INJ   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] MODE_SECC     = 2'd0;
    localparam logic [1:0] MODE_MECC     = 2'd1;
    localparam logic [1:0] MODE_ECC_INV  = 2'd2;
    localparam logic [1:0] MODE_FAILOVER = 2'd3;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Write delay in clocks between the sampled WRITE and the first data beat
    function automatic logic [3:0] cl_to_wd(input logic [2:0] cl);
        case (cl)
            3'd4:    return 4'd4;
            3'd5:    return 4'd6;
            3'd6:    return 4'd8;
            3'd7:    return 4'd10;
            default: return {1'b0, cl} - 4'd1;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/dimm_err_rr_arb.sv
// rtl/dimm_err_rr_arb.sv - 4-way round-robin arbiter with pointer register and one-hot grant
module dimm_err_rr_arb (
    input  logic       clk,
    input  logic       DRAM_RST_L,
    input  logic [3:0] req,
    input  logic       take,
    output logic       any,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] ptr_q;

    // First requester found scanning upward from the pointer, wrapping at 3
    always_comb begin
        any     = 1'b0;
        gnt_idx = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!any && req[ptr_q + 2'(i)]) begin
                any     = 1'b1;
                gnt_idx = ptr_q + 2'(i);
            end
        end
        gnt = any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    // Pointer moves just past the grantee whenever a grant is taken
    always_ff @(posedge clk or posedge DRAM_RST_L) begin
        if (DRAM_RST_L) begin
            ptr_q <= 2'd0;
        end else if (take && any) begin
            ptr_q <= gnt_idx + 2'd1;
        end
    end

endmodule

// File: rtl/dimm_err_inj_sched.sv
// rtl/dimm_err_inj_sched.sv - error-injection scheduler top; optional bank filter under DIMM_ERR_INJ_BANK_FILTER_EN
module dimm_err_inj_sched
    import dimm_err_inj_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int BURST_BEATS = 4,
    parameter int ARM_TIMEOUT = 1500
) (
    input  logic              clk,
    input  logic              DRAM_RST_L,
    input  logic [1:0]        DRAM_CS_L,
    input  logic [2:0]        DRAM_BA,
    input  logic              DRAM_RAS_L,
    input  logic              DRAM_CAS_L,
    input  logic              DRAM_WE_L,
    input  logic [2:0]        cas_latency,
    input  logic [2:0]        bank_sel,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_mode,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   req_abort,
    output logic              busy,
    output logic              inj_en,
    output logic [1:0]        inj_mode,
    output logic [1:0]        inj_beat,
    output logic [4:0]        inj_nib,
    output logic [3:0]        inj_bits
);

    localparam int TW = $clog2(ARM_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [1:0]    gidx_q;
    logic [1:0]    mode_q;
    logic [3:0]    wd_q;
    logic [TW-1:0] tmo_q;
    logic [3:0]    wait_q;
    logic [1:0]    beat_q;
    logic [15:0]   lfsr_q;

    logic          arb_any;
    logic [3:0]    arb_gnt;
    logic [1:0]    arb_idx;
    logic          arb_take;

    logic          bank_ok;
    logic          cmd_act;
    logic          cmd_wr;
    logic          tmo_hit;
    logic          wait_hit;
    logic          last_beat;

`ifdef DIMM_ERR_INJ_BANK_FILTER_EN
    assign bank_ok = (DRAM_BA === bank_sel);
    logic unused_cs;
    assign unused_cs = DRAM_CS_L[1];
`else
    assign bank_ok = 1'b1;
    logic unused_bank;
    assign unused_bank = ^{DRAM_CS_L[1], DRAM_BA, bank_sel};
`endif

    // Case-equality makes any X/Z on a command bit decode as no command
    assign cmd_act = bank_ok && (DRAM_CS_L[0] === 1'b0) && (DRAM_RAS_L === 1'b0) &&
                     (DRAM_CAS_L === 1'b1) && (DRAM_WE_L === 1'b1);
    assign cmd_wr  = bank_ok && (DRAM_CS_L[0] === 1'b0) && (DRAM_RAS_L === 1'b1) &&
                     (DRAM_CAS_L === 1'b0) && (DRAM_WE_L === 1'b0);

    assign tmo_hit   = (tmo_q == TW'(ARM_TIMEOUT - 1));
    assign wait_hit  = ((wait_q + 4'd1) == wd_q);
    assign last_beat = (beat_q == 2'(BURST_BEATS - 1));
    assign arb_take  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    dimm_err_rr_arb u_arb (
        .clk        (clk),
        .DRAM_RST_L (DRAM_RST_L),
        .req        (req_valid),
        .take       (arb_take),
        .any        (arb_any),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    // State register
    always_ff @(posedge clk or posedge DRAM_RST_L) begin
        if (DRAM_RST_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs; timeout is checked ahead of any command so it wins a tie
    always_comb begin
        state_d   = state_q;
        req_ack   = '0;
        req_abort = '0;
        inj_en    = 1'b0;
        inj_mode  = 2'd0;
        inj_beat  = 2'd0;
        inj_nib   = 5'd0;
        inj_bits  = 4'd0;
        case (state_q)
            IDLE: begin
                if (arb_any) state_d = ARMED;
            end
            ARMED: begin
                if (tmo_hit) begin
                    req_abort[gidx_q] = 1'b1;
                    state_d           = IDLE;
                end else if (cmd_act) begin
                    state_d = ACTV;
                end
            end
            ACTV: begin
                if (tmo_hit) begin
                    req_abort[gidx_q] = 1'b1;
                    state_d           = IDLE;
                end else if (cmd_wr) begin
                    state_d = (wd_q == 4'd0) ? INJ : WAIT;
                end
            end
            WAIT: begin
                if (wait_hit) state_d = INJ;
            end
            INJ: begin
                inj_en   = 1'b1;
                inj_mode = mode_q;
                inj_beat = beat_q;
                inj_nib  = (mode_q == MODE_ECC_INV) ? {3'b000, lfsr_q[1:0]} : lfsr_q[4:0];
                inj_bits = (lfsr_q[8:5] == 4'h0) ? 4'h1 : lfsr_q[8:5];
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                req_ack[gidx_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant capture, cycle counters and the pattern LFSR
    always_ff @(posedge clk or posedge DRAM_RST_L) begin
        if (DRAM_RST_L) begin
            gidx_q <= 2'd0;
            mode_q <= 2'd0;
            wd_q   <= 4'd0;
            tmo_q  <= '0;
            wait_q <= 4'd0;
            beat_q <= 2'd0;
            lfsr_q <= LFSR_SEED;
        end else begin
            if (state_q == IDLE && arb_any) begin
                gidx_q <= arb_idx;
                mode_q <= req_mode[{arb_idx, 1'b0} +: 2];
                wd_q   <= cl_to_wd(cas_latency);
            end
            tmo_q  <= (state_q == ARMED || state_q == ACTV) ? tmo_q + 1'b1 : '0;
            wait_q <= (state_q == WAIT) ? wait_q + 4'd1 : 4'd0;
            beat_q <= (state_q == INJ) ? beat_q + 2'd1 : 2'd0;
            if (inj_en) lfsr_q <= lfsr_step(lfsr_q);
        end
    end

endmodule

// File: tb/tb_dimm_err_inj_sched.sv
// tb/tb_dimm_err_inj_sched.sv - directed table-driven bench for dimm_err_inj_sched
module tb_dimm_err_inj_sched;

    logic       clk = 1'b0;
    logic       DRAM_RST_L;
    logic [1:0] DRAM_CS_L;
    logic [2:0] DRAM_BA;
    logic       DRAM_RAS_L, DRAM_CAS_L, DRAM_WE_L;
    logic [2:0] cas_latency, bank_sel;
    logic [3:0] req_valid;
    logic [7:0] req_mode;
    logic [3:0] req_ack, req_abort;
    logic       busy, inj_en;
    logic [1:0] inj_mode, inj_beat;
    logic [4:0] inj_nib;
    logic [3:0] inj_bits;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    typedef struct {
        logic [2:0] cl;
        logic [3:0] req;
        int         gap;
        logic [2:0] ba;
        bit         decoy;
        logic [3:0] gnt;
        logic [1:0] mode;
        int         lat;
    } vec_t;

    vec_t vt[8];

    dimm_err_inj_sched dut (
        .clk         (clk),
        .DRAM_RST_L  (DRAM_RST_L),
        .DRAM_CS_L   (DRAM_CS_L),
        .DRAM_BA     (DRAM_BA),
        .DRAM_RAS_L  (DRAM_RAS_L),
        .DRAM_CAS_L  (DRAM_CAS_L),
        .DRAM_WE_L   (DRAM_WE_L),
        .cas_latency (cas_latency),
        .bank_sel    (bank_sel),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ack     (req_ack),
        .req_abort   (req_abort),
        .busy        (busy),
        .inj_en      (inj_en),
        .inj_mode    (inj_mode),
        .inj_beat    (inj_beat),
        .inj_nib     (inj_nib),
        .inj_bits    (inj_bits)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic cs, input logic ras, input logic cas, input logic we,
                       input logic [2:0] ba);
        DRAM_CS_L  = {1'b1, cs};
        DRAM_RAS_L = ras;
        DRAM_CAS_L = cas;
        DRAM_WE_L  = we;
        DRAM_BA    = ba;
    endtask

    task automatic nop();
        cmd(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    endtask

    task automatic run_burst(input vec_t v, input bit hold, input int rst_at);
        int          n;
        bit          seen;
        logic [3:0]  eb;
        logic [4:0]  en;
        req_valid   = v.req;
        req_mode    = 8'hE4;
        cas_latency = v.cl;
        @(negedge clk);
        chk("grant_busy", busy, 1);
        if (!hold) req_valid = 4'b0000;
        cmd(1'b0, 1'b0, 1'b1, 1'b1, v.ba);
        @(negedge clk);
        for (int g = 0; g < v.gap; g++) begin
            if (g == 0) cmd(1'b0, 1'b0, 1'b1, 1'b1, v.ba);
            else nop();
            @(negedge clk);
        end
`ifdef DIMM_ERR_INJ_BANK_FILTER_EN
        if (v.decoy) begin
            cmd(1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
            @(negedge clk);
            nop();
            seen = 1'b0;
            repeat (12) begin
                @(negedge clk);
                if (inj_en) seen = 1'b1;
            end
            chk("bank_filter_no_inj", seen, 0);
        end
`endif
        cmd(1'b0, 1'b1, 1'b0, 1'b0, v.ba);
        @(negedge clk);
        nop();
        n = 1;
        while (inj_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_inj_latency", n, v.lat);
        for (int b = 0; b < 4; b++) begin
            if (b == rst_at) begin
                DRAM_RST_L = 1'b1;
                #1;
                chk("rst_inj_en", inj_en, 0);
                chk("rst_busy", busy, 0);
                @(negedge clk);
                chk("rst_no_ack_abort", {req_ack, req_abort}, 0);
                DRAM_RST_L = 1'b0;
                m_lfsr     = 16'hACE1;
                req_valid  = 4'b0000;
                return;
            end
            eb = m_lfsr[8:5];
            if (eb == 4'h0) eb = 4'h1;
            en = (v.mode == 2'd2) ? {3'b000, m_lfsr[1:0]} : m_lfsr[4:0];
            chk("inj_en", inj_en, 1);
            chk("inj_beat", inj_beat, b);
            chk("inj_mode", inj_mode, v.mode);
            chk("inj_nib", inj_nib, en);
            chk("inj_bits", inj_bits, eb);
            chk("bits_nonzero", inj_bits != 4'h0, 1);
            if (v.mode == 2'd2) chk("nib_cb_range", inj_nib <= 5'd3, 1);
            m_lfsr = lfsr_next(m_lfsr);
            @(negedge clk);
        end
        chk("ack_onehot", req_ack, v.gnt);
        chk("done_busy", busy, 1);
        chk("done_inj_off", inj_en, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("ack_pulse_width", req_ack, 0);
    endtask

    initial begin
        vec_t rr;
        int   n;

        vt[0] = '{3'd3, 4'b0001, 4, 3'd3, 1'b0, 4'b0001, 2'd0, 3};
        vt[1] = '{3'd6, 4'b0001, 2, 3'd3, 1'b0, 4'b0001, 2'd0, 9};
        vt[2] = '{3'd4, 4'b0110, 0, 3'd3, 1'b0, 4'b0010, 2'd1, 5};
        vt[3] = '{3'd5, 4'b0011, 3, 3'd3, 1'b0, 4'b0001, 2'd0, 7};
        vt[4] = '{3'd7, 4'b1001, 1, 3'd3, 1'b0, 4'b1000, 2'd3, 11};
        vt[5] = '{3'd2, 4'b0100, 2, 3'd3, 1'b0, 4'b0100, 2'd2, 2};
        vt[6] = '{3'd1, 4'b1100, 1, 3'd3, 1'b0, 4'b1000, 2'd3, 1};
`ifdef DIMM_ERR_INJ_BANK_FILTER_EN
        vt[7] = '{3'd3, 4'b0100, 2, 3'd3, 1'b1, 4'b0100, 2'd2, 3};
`else
        vt[7] = '{3'd3, 4'b0100, 2, 3'd1, 1'b0, 4'b0100, 2'd2, 3};
`endif

        DRAM_RST_L  = 1'b1;
        nop();
        cas_latency = 3'd3;
        bank_sel    = 3'd3;
        req_valid   = 4'b1111;
        req_mode    = 8'hE4;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ack", req_ack, 0);
        chk("reset_abort", req_abort, 0);
        chk("reset_busy", busy, 0);
        chk("reset_inj_en", inj_en, 0);
        chk("reset_inj_mode", inj_mode, 0);
        chk("reset_inj_beat", inj_beat, 0);
        chk("reset_inj_nib", inj_nib, 0);
        chk("reset_inj_bits", inj_bits, 0);
        req_valid  = 4'b0000;
        DRAM_RST_L = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_burst(vt[i], 1'b0, -1);

        DRAM_RST_L = 1'b1;
        @(negedge clk);
        DRAM_RST_L = 1'b0;
        m_lfsr     = 16'hACE1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            rr = '{3'd4, 4'b1111, 1, 3'd3, 1'b0, 4'b0001 << (k % 4), 2'(k % 4), 5};
            run_burst(rr, 1'b1, -1);
        end
        req_valid = 4'b0000;
        @(negedge clk);

        req_valid = 4'b0100;
        @(negedge clk);
        chk("tmo_grant_busy", busy, 1);
        req_valid = 4'b0000;
        n = 1;
        while (req_abort === 4'b0000 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycle", n, 1500);
        chk("abort_onehot", req_abort, 4'b0100);
        chk("abort_cycle_busy", busy, 1);
        cmd(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        @(negedge clk);
        nop();
        chk("abort_busy_fall", busy, 0);
        chk("abort_pulse_width", req_abort, 0);
        chk("abort_no_ack", req_ack, 0);
        @(negedge clk);
        chk("act_in_idle_ignored", busy, 0);

        rr = '{3'd3, 4'b0001, 1, 3'd3, 1'b0, 4'b0001, 2'd0, 3};
        run_burst(rr, 1'b0, 2);
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run_burst(rr, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
